uart_status_framer: RTL
=======================

# uart_status_framer

Parametrised telemetry framer that turns `NUM_CH` labelled unsigned status values into an ASCII terminal frame and pushes it byte by byte into the UART transmit FIFO write port.
- Successor to the fixed-message UART poller: label text, channel count, value width and digit count are generics; the binary-to-decimal conversion is internal and sequential.
- Adds valid/ready backpressure, a per-frame value snapshot, overflow marking and a periodic screen clear.
- Sits between the robot status sources (counters, state registers) and the UART TX buffer, on the system clock.

## Interface
Parameters:
- `NUM_CH`, 4: number of channels per frame (1–16).
- `VAL_W`, 26: width of each unsigned channel value.
- `DIGITS`, 8: decimal digits printed per value (1–10).
- `LABEL_LEN`, 4: label characters per channel.
- `CLEAR_EVERY`, 1024: frame period of the `ESC[J` screen clear (≥1).

Ports:
- `clk`  in  1  system clock; one clock; all logic on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `run`  in  1  level; while high, frames are emitted back to back.
- `labels`  in  NUM_CH*LABEL_LEN*8  ASCII labels; channel c, char k at bits [(c*LABEL_LEN+k)*8 +: 8].
- `values`  in  NUM_CH*VAL_W  unsigned values; channel c at [c*VAL_W +: VAL_W].
- `byte_data`  out  8  byte to the FIFO.
- `byte_valid`  out  1  `byte_data` valid.
- `byte_ready`  in  1  FIFO can accept a byte (i.e. not full).
- `busy`  out  1  high from frame start until `frame_done`.
- `frame_done`  out  1  one-cycle pulse at frame completion.

## Operation
- Frame byte order:
  - Header `ESC [ H` (27, 91, 72).
  - When `frame_cnt`==0, additionally `ESC [ J` (27, 91, 74).
  - For each channel 0..NUM_CH-1: LABEL_LEN label bytes, `:`, space, DIGITS digits most-significant first with leading zeros, CR (13), LF (10).
- Frame length: 3 (+3 on clear frames) + NUM_CH*(LABEL_LEN+DIGITS+4) bytes.
- Snapshot: `labels` and `values` are registered in IDLE on the cycle a frame starts; input changes during the frame are ignored.
- Conversion:
  - Per channel, shift-add-3 double-dabble into a 4*DIGITS BCD register, performed in CONV before that channel's label is sent.
  - Overflow: if the snapshot value > 10^DIGITS−1 (elaboration-time constant), every digit position prints `#` (35).
- `frame_cnt`:
  - Counts completed frames, modulo CLEAR_EVERY.
  - Reset value 0, so the first frame after reset clears the screen.
- States and transitions:
  - IDLE: `run`=1 → HDR (snapshot taken).
  - HDR: after 3 or 6 accepted bytes → CONV with channel 0.
  - CONV: after VAL_W+1 cycles → LABEL.
  - LABEL → SEP → DIGIT → EOL.
  - EOL: if more channels remain → CONV with the next channel; otherwise → DONE.
  - DONE: one cycle, pulses `frame_done` and increments `frame_cnt` → IDLE.
- Dropping `run` mid-frame does not abort the frame; the next frame starts only when IDLE sees `run`=1.

## Timing
- Reset values: `byte_valid`=0, `byte_data`=0, `busy`=0, `frame_done`=0, state IDLE, `frame_cnt`=0.
- Reset mid-frame: the cycle after `rst` is sampled high, all outputs are at reset values; no partial frame resumes.
- Handshake:
  - A byte transfers on a cycle with `byte_valid` & `byte_ready`.
  - While `byte_valid` & !`byte_ready`, `byte_data` and `byte_valid` hold stable.
  - `byte_valid` never depends combinationally on `byte_ready`.
- Throughput: with `byte_ready` held at 1, one byte per cycle within HDR, LABEL, SEP, DIGIT and EOL.
- `byte_valid` is low during CONV (VAL_W+1 cycles per channel) and during DONE/IDLE.
- Latency:
  - `run` sampled high in IDLE → `busy`=1 and `byte_valid`=1 with byte 27 on the next cycle.
  - The last LF accepted → `frame_done`=1 on the next cycle.
  - `busy` falls together with `frame_done`.
  - With `run` held high, the next header is valid 2 cycles after `frame_done`.
- `frame_cnt` wraps from CLEAR_EVERY−1 to 0; with CLEAR_EVERY=1 every frame clears.

## Test plan
- Basic frame: NUM_CH=2, DIGITS=8, labels "RGHT"/"LEFT", values 1234/0, `byte_ready`=1, `run` pulsed → 27,91,72,27,91,74,"RGHT: 00001234\r\n","LEFT: 00000000\r\n" (38 bytes); one `frame_done`; then IDLE.
- Clear period: CLEAR_EVERY=3, `run` held → frames 0 and 3 are 38 bytes with `ESC[J`; frames 1 and 2 are 35 bytes without it.
- Backpressure: random `byte_ready` (~50 %) → byte stream identical to the basic-frame case; `byte_data` stable during every stalled cycle; no byte lost or duplicated.
- Overflow boundary: DIGITS=4; value 9999 → "9999"; value 10000 → "####"; value 0 → "0000".
- Snapshot: change `values` and `labels` every cycle after frame start → the frame shows only the start-cycle values.
- Reset mid-frame: assert `rst` during DIGIT of channel 1 → next cycle `byte_valid`=0 and `busy`=0; after release, the first frame includes `ESC[J`.

Source files
------------

// File: rtl/uart_status_framer.sv
// Telemetry framer: snapshots NUM_CH labelled values and streams them
// as an ASCII terminal frame over a valid/ready byte port.
module uart_status_framer #(
  parameter int NUM_CH      = 4,
  parameter int VAL_W       = 26,
  parameter int DIGITS      = 8,
  parameter int LABEL_LEN   = 4,
  parameter int CLEAR_EVERY = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          run,
  input  logic [NUM_CH*LABEL_LEN*8-1:0] labels,
  input  logic [NUM_CH*VAL_W-1:0]       values,
  output logic [7:0]                    byte_data,
  output logic                          byte_valid,
  input  logic                          byte_ready,
  output logic                          busy,
  output logic                          frame_done
);

  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int NW = $clog2(VAL_W + 1);
  localparam int FW = (CLEAR_EVERY > 1) ? $clog2(CLEAR_EVERY) : 1;
  localparam int BW = 4 * DIGITS;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  localparam logic [63:0] MAXV = pow10(DIGITS) - 64'd1;

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_CONV, S_LABEL,
    S_SEP, S_DIGIT, S_EOL, S_DONE
  } state_t;

  state_t state, state_n;

  logic [7:0]                    idx;
  logic [CW-1:0]                 ch;
  logic [NW-1:0]                 cnt;
  logic [VAL_W-1:0]              bin;
  logic [BW-1:0]                 bcd, bcd_adj;
  logic                          ovf;
  logic [FW-1:0]                 frame_cnt;
  logic [NUM_CH*LABEL_LEN*8-1:0] snap_lab;
  logic [NUM_CH*VAL_W-1:0]       snap_val;
  logic                          clr;
  logic                          last;

  assign clr = (frame_cnt == '0);

  always_comb begin
    bcd_adj = bcd;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd[d*4 +: 4] >= 4'd5)
        bcd_adj[d*4 +: 4] = bcd[d*4 +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n    = state;
    byte_valid = 1'b0;
    byte_data  = 8'd0;
    busy       = 1'b1;
    frame_done = 1'b0;
    last       = 1'b0;
    unique case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (run) state_n = S_HDR;
      end
      S_HDR: begin
        byte_valid = 1'b1;
        unique case (idx)
          8'd0, 8'd3: byte_data = 8'd27;
          8'd1, 8'd4: byte_data = 8'd91;
          8'd2:       byte_data = 8'd72;
          default:    byte_data = 8'd74;
        endcase
        last = (idx == (clr ? 8'd5 : 8'd2));
        if (byte_ready && last) state_n = S_CONV;
      end
      S_CONV: begin
        if (cnt == NW'(VAL_W)) state_n = S_LABEL;
      end
      S_LABEL: begin
        byte_valid = 1'b1;
        byte_data  = snap_lab[7:0];
        last       = (idx == 8'(LABEL_LEN - 1));
        if (byte_ready && last) state_n = S_SEP;
      end
      S_SEP: begin
        byte_valid = 1'b1;
        byte_data  = (idx == 8'd0) ? 8'd58 : 8'd32;
        last       = (idx == 8'd1);
        if (byte_ready && last) state_n = S_DIGIT;
      end
      S_DIGIT: begin
        byte_valid = 1'b1;
        byte_data  = ovf ? 8'd35 : {4'h3, bcd[BW-1 -: 4]};
        last       = (idx == 8'(DIGITS - 1));
        if (byte_ready && last) state_n = S_EOL;
      end
      S_EOL: begin
        byte_valid = 1'b1;
        byte_data  = (idx == 8'd0) ? 8'd13 : 8'd10;
        last       = (idx == 8'd1);
        if (byte_ready && last)
          state_n = (ch == CW'(NUM_CH - 1)) ? S_DONE : S_CONV;
      end
      S_DONE: begin
        busy       = 1'b0;
        frame_done = 1'b1;
        state_n    = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Labels, values and digits are consumed in order, so shift them out
  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= '0;
      ch        <= '0;
      cnt       <= '0;
      bin       <= '0;
      bcd       <= '0;
      ovf       <= 1'b0;
      frame_cnt <= '0;
      snap_lab  <= '0;
      snap_val  <= '0;
    end else begin
      if (state != state_n)              idx <= '0;
      else if (byte_valid && byte_ready) idx <= idx + 8'd1;
      case (state)
        S_IDLE: begin
          if (run) begin
            snap_lab <= labels;
            snap_val <= values;
            ch       <= '0;
          end
        end
        S_CONV: begin
          if (cnt == '0) begin
            bin      <= snap_val[VAL_W-1:0];
            bcd      <= '0;
            ovf      <= (64'(snap_val[VAL_W-1:0]) > MAXV);
            snap_val <= snap_val >> VAL_W;
          end else begin
            {bcd, bin} <= {bcd_adj, bin} << 1;
          end
          cnt <= (cnt == NW'(VAL_W)) ? '0 : cnt + 1'b1;
        end
        S_LABEL: if (byte_ready) snap_lab <= snap_lab >> 8;
        S_DIGIT: if (byte_ready) bcd <= bcd << 4;
        S_EOL:   if (byte_ready && last) ch <= ch + 1'b1;
        S_DONE: begin
          if (frame_cnt == FW'(CLEAR_EVERY - 1)) frame_cnt <= '0;
          else                                   frame_cnt <= frame_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
